adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one registered W-bit adder between N_REQ requesters.
- Each requester presents an operand pair over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The sum is computed in a dedicated cycle and returned on a single response channel, tagged with the requester id.
- Sits between the client modules and the shared adder resource. It is the sequencing/ownership point for that resource.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- W, 32: operand and sum width in bits.
- IDW, $clog2(N_REQ): width of the requester id.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_req_valid  input  N_REQ  per-requester request valid.
- i_req_a  input  N_REQ*W  operand A; requester k uses bits [k*W +: W].
- i_req_b  input  N_REQ*W  operand B; same packing as i_req_a.
- o_req_ready  output  N_REQ  per-requester accept; at most one bit set.
- o_rsp_valid  output  1  response valid.
- o_rsp_id  output  IDW  index of the requester that owns the response.
- o_rsp_sum  output  W  result, (a + b) mod 2^W; signed two's-complement wrap.
- i_rsp_ready  input  1  response consumer ready.
- o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, sampled on the i_clk edge while i_rst_n=0:
  - state=IDLE.
  - rr_ptr=N_REQ-1, so requester 0 has first priority.
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_sum=0, o_busy=0.
  - o_req_ready=0 while reset is asserted.
- State IDLE:
  - grant g = first index with i_req_valid set, scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - o_req_ready = one-hot(g), combinational from i_req_valid and rr_ptr, and only in IDLE.
  - No valid request: o_req_ready=0 and state stays IDLE.
  - On accept (valid & ready for g): capture a_g, b_g and id=g; set rr_ptr=g; next state CALC.
- State CALC (exactly 1 cycle):
  - sum_reg <= a + b, truncated to W bits; carry discarded.
  - next state RESP.
- State RESP:
  - o_rsp_valid=1.
  - o_rsp_sum and o_rsp_id are driven from registers and held stable until handshake.
  - On i_rsp_ready=1: response consumed; next state IDLE.
  - Without i_rsp_ready, stays in RESP indefinitely.
  - o_req_ready=0 throughout RESP.
- Timing:
  - Accept edge T: o_rsp_valid rises after edge T+1 and is visible in cycle T+2.
  - Minimum spacing between accepts is 3 cycles.
- Requester side:
  - A requester must hold valid and operands stable until ready.
  - The arbiter samples operands only on the accept cycle.
  - A requester may deassert valid before grant without effect.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- Single requester: it is granted on every IDLE visit regardless of rr_ptr.
- Reset asserted during CALC or RESP:
  - in-flight operation is dropped and no response is produced.
  - rr_ptr returns to N_REQ-1.
- i_rsp_ready while not in RESP: ignored.
- Outputs are registered except o_req_ready.

Test Plan:
- Reset then a single request: req0 a=5, b=7 accepted in cycle 1 → o_rsp_valid in cycle 3 with sum=12, id=0, and o_busy high in cycles 2-3.
- All four requesters valid continuously, i_rsp_ready=1 → grant order 0,1,2,3,0, with accepts every 3 cycles and each id's sum correct.
- Overflow: a=32'hFFFF_FFFF, b=2 → sum=1; a=32'h7FFF_FFFF, b=1 → sum=32'h8000_0000.
- Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP → o_rsp_valid, sum and id are stable throughout, and all o_req_ready stay 0; releasing ready returns to IDLE and the next grant follows.
- Reset mid-CALC with req2 in flight → no response is emitted; after reset, with req1 and req2 both valid, req1 is granted first.
- Only req3 valid, issued repeatedly → granted each time, and its id=3 appears on o_rsp_id.

Source files
------------

// File: rtl/adder_arbiter.sv
// One registered W-bit adder shared round-robin between N_REQ valid/ready requesters.
// Each grant is a fixed three-phase sequence: accept operands, add, hold the response until it is taken.
module adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 32,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [N_REQ*W-1:0] i_req_a,
   input  logic [N_REQ*W-1:0] i_req_b,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic               o_rsp_valid,
   output logic [IDW-1:0]     o_rsp_id,
   output logic [W-1:0]       o_rsp_sum,
   input  logic               i_rsp_ready,
   output logic               o_busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

   state_t                      state_q, state_d;
   logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]              id_q, id_d;
   logic [W-1:0]                a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [N_REQ-1:0][W-1:0]     req_a, req_b;
   logic                        gnt_vld, accept;
   logic [IDW-1:0]              gnt_id;

   assign req_a = i_req_a;
   assign req_b = i_req_b;

   // Scan starts just past the last winner, so the last winner has lowest priority.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!gnt_vld && i_req_valid[(int'(rr_ptr_q) + i) % N_REQ]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'((int'(rr_ptr_q) + i) % N_REQ);
         end
      end
   end

   assign accept      = (state_q == IDLE) && gnt_vld && i_rst_n;
   assign o_req_ready = accept ? (N_REQ'(1) << gnt_id) : '0;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d      = req_a[gnt_id];
               b_d      = req_b[gnt_id];
               id_d     = gnt_id;
               rr_ptr_d = gnt_id;
               state_d  = CALC;
            end
         end
         CALC: begin
            sum_d   = a_q + b_q;
            state_d = RESP;
         end
         RESP: begin
            if (i_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDW'(N_REQ - 1);
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
      end
   end

   assign o_rsp_valid = (state_q == RESP);
   assign o_busy      = (state_q != IDLE);
   assign o_rsp_id    = id_q;
   assign o_rsp_sum   = sum_q;

endmodule
